// File: rtl/uart_load_ctrl_pkg.sv
// Shared types for the UART program loader.
// Package uart_load_pkg: loader FSM state encoding, byte width, state helpers.
package uart_load_pkg;

    localparam int LOAD_BYTE_W = 8;

    typedef enum logic [3:0] {
        RUN     = 4'd0,
        HDR_LO  = 4'd1,
        HDR_HI  = 4'd2,
        DATA_LO = 4'd3,
        DATA_HI = 4'd4,
        WRITE   = 4'd5,
        CSUM_LO = 4'd6,
        CSUM_HI = 4'd7,
        DONE    = 4'd8,
        ERROR   = 4'd9
    } load_state_t;

    // States in which the loader is consuming the byte stream; dropping
    // load_en in any of them aborts the load.
    function automatic logic is_receiving(input load_state_t s);
        return (s inside {HDR_LO, HDR_HI, DATA_LO, DATA_HI, WRITE, CSUM_LO, CSUM_HI});
    endfunction

    // States in which the inter-byte timeout runs: everything after the first
    // header byte has arrived, up to the end of the stream.
    function automatic logic timer_active(input load_state_t s);
        return (s inside {HDR_HI, DATA_LO, DATA_HI, WRITE, CSUM_LO, CSUM_HI});
    endfunction

endpackage

// File: rtl/uart_load_ctrl_timer.sv
// load_timer: inter-byte timeout counter for the UART program loader.
// Counts enabled cycles since the last accepted byte and pulses expired_o
// when the count reaches TIMEOUT_CYCLES-1.
module load_timer #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic clk,
    input  logic rst,        // synchronous, active low
    input  logic clr_i,      // a byte was accepted this cycle
    input  logic en_i,       // loader is waiting on the stream
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on every byte or while idle, saturate at the limit.
    always_comb begin
        cnt_d     = cnt_q;
        expired_o = 1'b0;
        if (clr_i || !en_i) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            expired_o = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_load_ctrl.sv
// uart_load_ctrl: arbitrates the program-memory data port between the UART
// loader and the CPU. Load mode frames header / data words / optional
// checksum and writes words to sequential addresses with the CPU held in
// reset; run mode passes CPU traffic straight through.
// Optional feature macro: UART_LOAD_CSUM_EN (trailing 16-bit checksum word).
module uart_load_ctrl
    import uart_load_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int WORD_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                   clk,
    input  logic                   rst,        // synchronous, active low
    input  logic                   load_en,
    input  logic                   rx_valid,
    input  logic [LOAD_BYTE_W-1:0] rx_byte,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [WORD_WIDTH-1:0]  cpu_wdata,
    input  logic                   cpu_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [WORD_WIDTH-1:0]  mem_wdata,
    output logic                   mem_we,
    output logic                   cpu_rst_n,
    output logic [15:0]            load_count,
    output logic                   load_done,
    output logic                   load_err
);

    // Largest legal header value: one word per addressable location.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

    load_state_t            state_q, state_d;
    logic [LOAD_BYTE_W-1:0] lo_q, lo_d;          // pending low byte
    logic [15:0]            n_q, n_d;            // header word count
    logic [15:0]            count_q, count_d;    // words written = write index
    logic [ADDR_WIDTH-1:0]  waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   cpu_rst_n_q, cpu_rst_n_d;
    logic                   load_en_q;
`ifdef UART_LOAD_CSUM_EN
    logic [15:0]            csum_q, csum_d;
`endif

    logic        expired;
    logic [15:0] rx_word;
    logic [16:0] next_idx;
    logic        run_mode;

    load_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (rx_valid && is_receiving(state_q)),
        .en_i     (timer_active(state_q)),
        .expired_o(expired)
    );

    assign rx_word  = {rx_byte, lo_q};
    assign next_idx = {1'b0, count_q} + 17'd1;

    // Next-state and datapath updates for the loader FSM.
    always_comb begin
        state_d = state_q;
        lo_d    = lo_q;
        n_d     = n_q;
        count_d = count_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef UART_LOAD_CSUM_EN
        csum_d  = csum_q;
`endif

        case (state_q)
            RUN: begin
                if (load_en) state_d = HDR_LO;
            end
            HDR_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_byte;
                    state_d = HDR_HI;
                end
            end
            HDR_HI: begin
                if (rx_valid) begin
                    n_d = rx_word;
                    if ({17'd0, rx_word} > MAX_WORDS) begin
                        state_d = ERROR;
                    end else if (rx_word == 16'd0) begin
`ifdef UART_LOAD_CSUM_EN
                        state_d = CSUM_LO;
`else
                        state_d = DONE;
`endif
                    end else begin
                        state_d = DATA_LO;
                    end
                end
            end
            DATA_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_byte;
                    state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (rx_valid) begin
                    waddr_d = ADDR_WIDTH'(count_q);
                    wdata_d = WORD_WIDTH'(rx_word);
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // A byte arriving in this cycle already belongs to the next
                // word (or the checksum), so it is captured as a low byte.
                count_d = next_idx[15:0];
`ifdef UART_LOAD_CSUM_EN
                csum_d  = csum_q + 16'(wdata_q);
`endif
                if (next_idx < {1'b0, n_q}) begin
                    if (rx_valid) begin
                        lo_d    = rx_byte;
                        state_d = DATA_HI;
                    end else begin
                        state_d = DATA_LO;
                    end
                end else begin
`ifdef UART_LOAD_CSUM_EN
                    if (rx_valid) begin
                        lo_d    = rx_byte;
                        state_d = CSUM_HI;
                    end else begin
                        state_d = CSUM_LO;
                    end
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef UART_LOAD_CSUM_EN
            CSUM_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_byte;
                    state_d = CSUM_HI;
                end
            end
            CSUM_HI: begin
                if (rx_valid) begin
                    state_d = (rx_word == csum_q) ? DONE : ERROR;
                end
            end
`endif
            DONE: begin
                if (!load_en) state_d = RUN;
            end
            ERROR: begin
                // Only a fresh rising edge of load_en restarts a load.
                if (load_en && !load_en_q) state_d = HDR_LO;
            end
            default: state_d = ERROR;
        endcase

        // Abort and timeout override any stream progress.
        if (is_receiving(state_q)) begin
            if (!load_en || expired) state_d = ERROR;
        end

        // Entry into a new load clears the per-load bookkeeping.
        if (state_d == HDR_LO && state_q != HDR_LO) begin
            count_d = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
`ifdef UART_LOAD_CSUM_EN
            csum_d  = '0;
`endif
        end
        if (state_d == DONE)  done_d = 1'b1;
        if (state_d == ERROR) err_d  = 1'b1;

        // CPU runs only while the controller sits in RUN.
        cpu_rst_n_d = (state_d == RUN);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            lo_q        <= '0;
            n_q         <= '0;
            count_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            load_en_q   <= 1'b0;
`ifdef UART_LOAD_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lo_q        <= lo_d;
            n_q         <= n_d;
            count_q     <= count_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            load_en_q   <= load_en;
`ifdef UART_LOAD_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    // Pass-through only once the CPU has left reset, so the port shows the
    // loader's registered values during and straight after rst.
    assign run_mode = (state_q == RUN) && cpu_rst_n_q;

    // Memory data-port mux: CPU in run mode, loader registers otherwise.
    always_comb begin
        if (run_mode) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
        end else begin
            mem_addr  = waddr_q;
            mem_wdata = wdata_q;
            mem_we    = (state_q == WRITE);
        end
    end

    assign cpu_rst_n  = cpu_rst_n_q;
    assign load_count = count_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_uart_load_ctrl.sv
// Directed testbench for uart_load_ctrl (timeout reduced to 100 cycles).
// Covers the checksum variant too when UART_LOAD_CSUM_EN is defined.
module tb_uart_load_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_en;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_rst_n;
    logic [15:0] load_count;
    logic        load_done;
    logic        load_err;

    int tests = 0;
    int fails = 0;

    logic [31:0] wq[$];
    int run_len = 0;
    int max_run = 0;

    uart_load_ctrl #(
        .ADDR_WIDTH    (16),
        .WORD_WIDTH    (16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_en   (load_en),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_rst_n (cpu_rst_n),
        .load_count(load_count),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Record every loader-side write and the longest mem_we run.
    always @(negedge clk) begin
        if (mem_we && !cpu_rst_n) begin
            wq.push_back({mem_addr, mem_wdata});
            $display("[TB] write addr=0x%04h data=0x%04h", mem_addr, mem_wdata);
            run_len++;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? wq[i] : 32'hDEAD_DEAD;
    endfunction

    task automatic drive_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        $display("[TB] rx byte 0x%02h", b);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_byte(b);
        drop_valid();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Produce a fresh rising edge of load_en (works from RUN and ERROR).
    task automatic start_load();
        @(negedge clk);
        load_en = 1'b0;
        @(negedge clk);
        load_en = 1'b1;
        @(negedge clk);
        wq.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'd0);
        chk({tag, "_mem_we"},    32'(mem_we),    32'd0);
        chk({tag, "_count"},     32'(load_count), 32'd0);
        chk({tag, "_done"},      32'(load_done), 32'd0);
        chk({tag, "_err"},       32'(load_err),  32'd0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    endtask

    initial begin
        rst = 1'b0; load_en = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        cpu_addr = 16'h0; cpu_wdata = 16'h0; cpu_we = 1'b0;

        // Reset state.
        idle(2);
        chk_reset_outputs("reset");

        // Release: CPU leaves reset one cycle later.
        rst = 1'b1;
        @(negedge clk);
        chk("cpu_rst_n_release", 32'(cpu_rst_n), 32'd1);

        // Run-mode pass-through, zero latency.
        cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 16'hBEEF;
        #1;
        chk("pt_we",    32'(mem_we),    32'd1);
        chk("pt_addr",  32'(mem_addr),  32'h0040);
        chk("pt_wdata", 32'(mem_wdata), 32'hBEEF);
        @(negedge clk);
        cpu_we = 1'b0;

        // Basic two-word load.
        load_en = 1'b1;
        @(negedge clk);
        wq.delete();
        chk("t1_cpu_rst_fall", 32'(cpu_rst_n), 32'd0);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        chk("t1_we_lat",    32'(mem_we),     32'd1);
        chk("t1_addr0",     32'(mem_addr),   32'h0000);
        chk("t1_data0",     32'(mem_wdata),  32'h1234);
        chk("t1_cnt_pre",   32'(load_count), 32'd0);
        @(negedge clk);
        chk("t1_we_low",    32'(mem_we),     32'd0);
        chk("t1_cnt_post",  32'(load_count), 32'd1);
        send_byte(8'h78); send_byte(8'h56);
`ifdef UART_LOAD_CSUM_EN
        send_byte(8'hAC); send_byte(8'h68);
`endif
        idle(3);
        chk("t1_nwrites", 32'(wq.size()), 32'd2);
        chk("t1_w0",      wq_at(0), {16'h0000, 16'h1234});
        chk("t1_w1",      wq_at(1), {16'h0001, 16'h5678});
        chk("t1_count",   32'(load_count), 32'd2);
        chk("t1_done",    32'(load_done),  32'd1);
        chk("t1_err",     32'(load_err),   32'd0);
        chk("t1_cpu_held",32'(cpu_rst_n),  32'd0);
        load_en = 1'b0;
        @(negedge clk);
        chk("t1_cpu_run", 32'(cpu_rst_n), 32'd1);
        chk("t1_done_kept", 32'(load_done), 32'd1);

        // Back-to-back bytes: one arrives during the WRITE cycle.
        start_load();
        drive_byte(8'h02); drive_byte(8'h00);
        drive_byte(8'hA1); drive_byte(8'hB2);
        drive_byte(8'hC3); drive_byte(8'hD4);
`ifdef UART_LOAD_CSUM_EN
        drive_byte(8'h64); drive_byte(8'h87);
`endif
        drop_valid();
        idle(3);
        chk("t2_nwrites", 32'(wq.size()), 32'd2);
        chk("t2_w0",      wq_at(0), {16'h0000, 16'hB2A1});
        chk("t2_w1",      wq_at(1), {16'h0001, 16'hD4C3});
        chk("t2_count",   32'(load_count), 32'd2);
        chk("t2_done",    32'(load_done),  32'd1);

        // Zero-length load.
        start_load();
        send_byte(8'h00); send_byte(8'h00);
`ifdef UART_LOAD_CSUM_EN
        send_byte(8'h00); send_byte(8'h00);
`endif
        idle(2);
        chk("t3_done",    32'(load_done),  32'd1);
        chk("t3_err",     32'(load_err),   32'd0);
        chk("t3_count",   32'(load_count), 32'd0);
        chk("t3_nwrites", 32'(wq.size()),  32'd0);
`ifdef UART_LOAD_CSUM_EN
        // Zero-length load with a wrong checksum.
        start_load();
        send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h00);
        idle(2);
        chk("t3c_err",  32'(load_err),  32'd1);
        chk("t3c_done", 32'(load_done), 32'd0);
`endif

        // Inter-byte timeout after one of three words.
        start_load();
        send_byte(8'h03); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22);
        idle(50);
        chk("t4_no_early_err", 32'(load_err), 32'd0);
        for (int i = 0; i < 100 && !load_err; i++) @(negedge clk);
        chk("t4_err",     32'(load_err),   32'd1);
        chk("t4_count",   32'(load_count), 32'd1);
        chk("t4_cpu_rst", 32'(cpu_rst_n),  32'd0);
        chk("t4_done",    32'(load_done),  32'd0);

        // Abort: load_en dropped after 1 of 4 words.
        start_load();
        send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h55); send_byte(8'h66);
        load_en = 1'b0;
        @(negedge clk);
        chk("t5_err",   32'(load_err),   32'd1);
        chk("t5_count", 32'(load_count), 32'd1);
        idle(3);
        chk("t5_cpu_rst", 32'(cpu_rst_n), 32'd0);
        chk("t5_w0",      wq_at(0), {16'h0000, 16'h6655});

        // Reset mid-load.
        start_load();
        send_byte(8'h04); send_byte(8'h00); send_byte(8'h77);
        rst = 1'b0;
        load_en = 1'b0;
        @(negedge clk);
        chk_reset_outputs("t6");
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cpu_run", 32'(cpu_rst_n), 32'd1);

        chk("we_pulse_width", 32'(max_run), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
